// File: rtl/regfile_mp_pkg.sv
// Shared constants and typedefs for the multi-port register file with
// pending-write scoreboard. Optional build macro: REGFILE_MP_BYPASS_EN
// (same-cycle write-to-read forwarding, implemented in regfile_mp).
package regfile_mp_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_RD_DEF   = 2;
  localparam int NUM_WR_DEF   = 2;
  localparam int ZERO_REG_DEF = 1;

  typedef logic [DATA_W_DEF-1:0] data_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

  // Number of architectural registers addressed by an addr_w-bit index.
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bundles the write ports, read ports and reservation request of the
// register file. The master side issues writes/reads/reservations and the
// slave side (the register file) returns data and scoreboard status.
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF,
  parameter int NUM_WR = NUM_WR_DEF
);

  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     rsv_ok;
  logic [(2**ADDR_W)-1:0]   busy_vec;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr,
    input  rd_data, rd_busy, rsv_ok, busy_vec
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr,
    output rd_data, rd_busy, rsv_ok, busy_vec
  );

endinterface

// File: rtl/regfile_mp_sb.sv
// Pending-write scoreboard: one busy bit per register. A reservation marks a
// register as awaiting a result, any write to it completes that result. When
// both hit the same register in one cycle the accepted reservation wins, so
// the register stays pending for the new producer.
module regfile_mp_sb
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_WR   = NUM_WR_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_ok,
  output logic [(2**ADDR_W)-1:0]   busy_vec
);

  logic [(2**ADDR_W)-1:0] busy_next;
  logic                   rsv_zero;
  logic                   rsv_set;

  // Accept a reservation when the target is free; the hardwired zero
  // register is always accepted but never tracked. Nothing is accepted in reset.
  always_comb begin
    rsv_zero = (ZERO_REG != 0) && (rsv_addr == '0);
    rsv_ok   = rsv_en && !reset && (rsv_zero || !busy_vec[rsv_addr]);
    rsv_set  = rsv_ok && !rsv_zero;
  end

  // Next busy state: writes clear first, then an accepted reservation sets,
  // giving set-over-clear priority on a same-address collision.
  always_comb begin
    busy_next = busy_vec;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_en[k]) begin
        busy_next[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (rsv_set) begin
      busy_next[rsv_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busy_next[0] = 1'b0;
    end
  end

  // Scoreboard register, wiped asynchronously so no reservation survives reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= busy_next;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with combinational reads, prioritised writes
// (highest-index write port wins) and an attached pending-write scoreboard.
// Optional build macro: REGFILE_MP_BYPASS_EN forwards same-cycle write data
// to the read ports; without it reads return the pre-write contents.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = NUM_RD_DEF,
  parameter int NUM_WR   = NUM_WR_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic clk,
  input  logic reset,
  regfile_mp_if.slave bus
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0]        mem [DEPTH];
  logic [NUM_RD*DATA_W-1:0] rd_data_c;
  logic [NUM_RD-1:0]        rd_busy_c;
  logic [ADDR_W-1:0]        ra;
  logic [ADDR_W-1:0]        wa;
  logic [DATA_W-1:0]        rdata;
  logic                     rbusy;
`ifdef REGFILE_MP_BYPASS_EN
  logic                     wr_hit;
`endif

  regfile_mp_sb #(
    .ADDR_W   (ADDR_W),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .rsv_ok   (bus.rsv_ok),
    .busy_vec (bus.busy_vec)
  );

  // Register storage: ports applied in ascending order so the highest index
  // wins a same-address collision; writes to a hardwired zero register drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (bus.wr_en[k] &&
            !((ZERO_REG != 0) && (bus.wr_addr[k*ADDR_W +: ADDR_W] == '0))) begin
          mem[bus.wr_addr[k*ADDR_W +: ADDR_W]] <= bus.wr_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Read muxing for every read port, with optional same-cycle forwarding of
  // the winning write and forced zeros for register 0 and during reset.
  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    ra        = '0;
    wa        = '0;
    rdata     = '0;
    rbusy     = 1'b0;
`ifdef REGFILE_MP_BYPASS_EN
    wr_hit    = 1'b0;
`endif
    for (int j = 0; j < NUM_RD; j++) begin
      ra    = bus.rd_addr[j*ADDR_W +: ADDR_W];
      rdata = mem[ra];
      rbusy = bus.busy_vec[ra];
`ifdef REGFILE_MP_BYPASS_EN
      wr_hit = 1'b0;
      for (int k = 0; k < NUM_WR; k++) begin
        wa = bus.wr_addr[k*ADDR_W +: ADDR_W];
        if (bus.wr_en[k] && (wa == ra)) begin
          rdata  = bus.wr_data[k*DATA_W +: DATA_W];
          wr_hit = 1'b1;
        end
      end
      if (wr_hit) begin
        rbusy = bus.rsv_ok && (bus.rsv_addr == ra) &&
                !((ZERO_REG != 0) && (ra == '0));
      end
`endif
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rdata = '0;
        rbusy = 1'b0;
      end
      if (reset) begin
        rdata = '0;
        rbusy = 1'b0;
      end
      rd_data_c[j*DATA_W +: DATA_W] = rdata;
      rd_busy_c[j]                  = rbusy;
    end
  end

  assign bus.rd_data = rd_data_c;
  assign bus.rd_busy = rd_busy_c;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed testbench for regfile_mp (default parameters). Expected values are
// queued as each step is driven and compared when the outputs settle.
// Honours REGFILE_MP_BYPASS_EN to select same-cycle read expectations.
module tb_regfile_mp;
  import regfile_mp_pkg::*;

  localparam int K_RD0 = 0;
  localparam int K_RD1 = 1;
  localparam int K_OK  = 2;
  localparam int K_BV  = 3;
  localparam int K_RB0 = 4;
  localparam int K_RB1 = 5;

`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  logic  clk;
  logic  reset;
  int    checks;
  int    errors;
  exp_t  sbq[$];
  data_t model_mem [32];
  data_t d0;
  data_t d1;

  regfile_mp_if bus ();

  regfile_mp dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_RD0:   return bus.rd_data[31:0];
      K_RD1:   return bus.rd_data[63:32];
      K_OK:    return {31'b0, bus.rsv_ok};
      K_BV:    return bus.busy_vec;
      K_RB0:   return {31'b0, bus.rd_busy[0]};
      default: return {31'b0, bus.rd_busy[1]};
    endcase
  endfunction

  task automatic push_exp(input int kind, input string tag, input logic [31:0] exp);
    exp_t e;
    e.kind = kind;
    e.tag  = tag;
    e.exp  = exp;
    sbq.push_back(e);
  endtask

  // Drive one cycle of inputs just after a rising edge, then let them settle.
  task automatic applyStimulus(input logic [1:0] we,
                               input addr_t wa0, input data_t wd0,
                               input addr_t wa1, input data_t wd1,
                               input addr_t ra0, input addr_t ra1,
                               input logic re, input addr_t rsa);
    @(posedge clk);
    #1;
    bus.wr_en    = we;
    bus.wr_addr  = {wa1, wa0};
    bus.wr_data  = {wd1, wd0};
    bus.rd_addr  = {ra1, ra0};
    bus.rsv_en   = re;
    bus.rsv_addr = rsa;
    #3;
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [31:0] obs;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      obs = observe(e.kind);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.wr_en = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_addr = '0; bus.rsv_en = 1'b0; bus.rsv_addr = '0;
    for (int i = 0; i < 32; i++) model_mem[i] = '0;

    // Writes and reservations during reset are ignored; outputs held at zero.
    applyStimulus(2'b11, 5'd4, 32'hAAAA_AAAA, 5'd4, 32'hBBBB_BBBB, 5'd4, 5'd4, 1'b1, 5'd4);
    push_exp(K_RD0, "reset_rd0", 32'h0);
    push_exp(K_OK,  "reset_rsv_ok", 32'h0);
    push_exp(K_BV,  "reset_busy_vec", 32'h0);
    push_exp(K_RB0, "reset_rd_busy0", 32'h0);
    checkOutput();
    applyStimulus(2'b00, 5'd0, '0, 5'd0, '0, 5'd4, 5'd4, 1'b0, 5'd0);
    reset = 1'b0;
    applyStimulus(2'b00, 5'd0, '0, 5'd0, '0, 5'd4, 5'd4, 1'b0, 5'd0);
    push_exp(K_RD0, "post_reset_rd4", 32'h0);
    push_exp(K_BV,  "post_reset_busy_vec", 32'h0);
    checkOutput();

    // Every register reads zero on both ports after reset.
    for (int a = 0; a < 32; a++) begin
      applyStimulus(2'b00, 5'd0, '0, 5'd0, '0, 5'(a), 5'(31 - a), 1'b0, 5'd0);
      push_exp(K_RD0, $sformatf("zero_rd0_a%0d", a), 32'h0);
      push_exp(K_RD1, $sformatf("zero_rd1_a%0d", 31 - a), 32'h0);
      checkOutput();
    end

    // Both ports write address 5: port 1 must win.
    applyStimulus(2'b11, 5'd5, 32'h1111_1111, 5'd5, 32'h2222_2222, 5'd5, 5'd0, 1'b0, 5'd0);
    push_exp(K_RD0, "dual_wr_same_cycle", BYP ? 32'h2222_2222 : 32'h0);
    push_exp(K_RB0, "dual_wr_rd_busy0", 32'h0);
    checkOutput();
    applyStimulus(2'b00, 5'd0, '0, 5'd0, '0, 5'd5, 5'd0, 1'b0, 5'd0);
    push_exp(K_RD0, "dual_wr_port1_wins", 32'h2222_2222);
    push_exp(K_BV,  "dual_wr_busy_vec", 32'h0);
    checkOutput();

    // Register 0 ignores writes and reservations.
    applyStimulus(2'b01, 5'd0, 32'hDEAD_BEEF, 5'd0, '0, 5'd0, 5'd0, 1'b1, 5'd0);
    push_exp(K_RD0, "zero_reg_wr_same", 32'h0);
    push_exp(K_OK,  "zero_reg_rsv_ok", 32'h1);
    checkOutput();
    applyStimulus(2'b00, 5'd0, '0, 5'd0, '0, 5'd0, 5'd0, 1'b0, 5'd0);
    push_exp(K_RD0, "zero_reg_wr_next", 32'h0);
    push_exp(K_BV,  "zero_reg_never_busy", 32'h0);
    checkOutput();

    // Reserve 7, re-reserve rejected, write+reserve while busy ends clear,
    // write+reserve while clear ends set.
    applyStimulus(2'b00, 5'd0, '0, 5'd0, '0, 5'd0, 5'd7, 1'b1, 5'd7);
    push_exp(K_OK,  "rsv7_first_ok", 32'h1);
    push_exp(K_RB1, "rsv7_no_lookahead", 32'h0);
    checkOutput();
    applyStimulus(2'b00, 5'd0, '0, 5'd0, '0, 5'd0, 5'd7, 1'b1, 5'd7);
    push_exp(K_OK,  "rsv7_again_rejected", 32'h0);
    push_exp(K_BV,  "rsv7_busy_vec", 32'h0000_0080);
    push_exp(K_RB1, "rsv7_rd_busy1", 32'h1);
    checkOutput();
    applyStimulus(2'b10, 5'd0, '0, 5'd7, 32'h0000_0077, 5'd0, 5'd7, 1'b1, 5'd7);
    push_exp(K_OK,  "wr7_busy_rsv_rejected", 32'h0);
    push_exp(K_RB1, "wr7_busy_rd_busy1", BYP ? 32'h0 : 32'h1);
    push_exp(K_RD1, "wr7_busy_rd_data1", BYP ? 32'h0000_0077 : 32'h0);
    checkOutput();
    applyStimulus(2'b10, 5'd0, '0, 5'd7, 32'h0000_0078, 5'd0, 5'd7, 1'b1, 5'd7);
    push_exp(K_BV,  "wr7_cleared_busy", 32'h0);
    push_exp(K_OK,  "wr7_clear_rsv_ok", 32'h1);
    push_exp(K_RB1, "wr7_rsv_rd_busy1", BYP ? 32'h1 : 32'h0);
    push_exp(K_RD1, "wr7_rsv_rd_data1", BYP ? 32'h0000_0078 : 32'h0000_0077);
    checkOutput();
    applyStimulus(2'b00, 5'd0, '0, 5'd0, '0, 5'd0, 5'd7, 1'b0, 5'd0);
    push_exp(K_BV,  "wr7_rsv_wins_busy", 32'h0000_0080);
    push_exp(K_RD1, "wr7_rsv_data", 32'h0000_0078);
    push_exp(K_RB1, "wr7_rsv_rd_busy1_next", 32'h1);
    checkOutput();

    // Write-then-read timing on address 3.
    applyStimulus(2'b01, 5'd3, 32'h0000_0033, 5'd0, '0, 5'd0, 5'd0, 1'b0, 5'd0);
    applyStimulus(2'b01, 5'd3, 32'hCAFE_0001, 5'd0, '0, 5'd3, 5'd0, 1'b0, 5'd0);
    push_exp(K_RD0, "wr3_same_cycle", BYP ? 32'hCAFE_0001 : 32'h0000_0033);
    checkOutput();
    applyStimulus(2'b00, 5'd0, '0, 5'd0, '0, 5'd3, 5'd0, 1'b0, 5'd0);
    push_exp(K_RD0, "wr3_next_cycle", 32'hCAFE_0001);
    checkOutput();

    // Burst of random writes on both ports (16 collides), then read back all.
    for (int a = 1; a <= 16; a++) begin
      d0 = $urandom;
      d1 = $urandom;
      applyStimulus(2'b11, 5'(a), d0, 5'(32 - a), d1, 5'd0, 5'd0, 1'b0, 5'd0);
      model_mem[a]      = d0;
      model_mem[32 - a] = d1;
    end
    applyStimulus(2'b00, 5'd0, '0, 5'd0, '0, 5'd0, 5'd0, 1'b0, 5'd0);
    push_exp(K_BV, "burst_busy_cleared", 32'h0);
    checkOutput();
    for (int a = 0; a < 32; a++) begin
      applyStimulus(2'b00, 5'd0, '0, 5'd0, '0, 5'(a), 5'(31 - a), 1'b0, 5'd0);
      push_exp(K_RD0, $sformatf("burst_rd0_a%0d", a), model_mem[a]);
      push_exp(K_RD1, $sformatf("burst_rd1_a%0d", 31 - a), model_mem[31 - a]);
      checkOutput();
    end

    // Reset mid-cycle with register 9 busy and holding data.
    applyStimulus(2'b01, 5'd9, 32'h0000_0055, 5'd0, '0, 5'd0, 5'd0, 1'b1, 5'd9);
    push_exp(K_OK, "r9_rsv_ok", 32'h1);
    checkOutput();
    applyStimulus(2'b00, 5'd0, '0, 5'd0, '0, 5'd9, 5'd9, 1'b0, 5'd0);
    push_exp(K_RD0, "r9_data", 32'h0000_0055);
    push_exp(K_BV,  "r9_busy_vec", 32'h0000_0200);
    push_exp(K_RB0, "r9_rd_busy0", 32'h1);
    checkOutput();
    #2;
    reset        = 1'b1;
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = 5'd9;
    #1;
    push_exp(K_RD0, "midreset_rd0", 32'h0);
    push_exp(K_RD1, "midreset_rd1", 32'h0);
    push_exp(K_BV,  "midreset_busy_vec", 32'h0);
    push_exp(K_RB0, "midreset_rd_busy0", 32'h0);
    push_exp(K_OK,  "midreset_rsv_ok", 32'h0);
    checkOutput();
    @(posedge clk);
    #1;
    bus.rsv_en = 1'b0;
    reset      = 1'b0;
    applyStimulus(2'b00, 5'd0, '0, 5'd0, '0, 5'd9, 5'd5, 1'b0, 5'd0);
    push_exp(K_RD0, "after_reset_r9", 32'h0);
    push_exp(K_RD1, "after_reset_r5", 32'h0);
    push_exp(K_BV,  "after_reset_busy_vec", 32'h0);
    checkOutput();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; depth = 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2: number of read ports.
REQ-004 Parameter NUM_WR, default 2: number of write ports.
REQ-005 Parameter ZERO_REG, default 1: 1 = register 0 hardwired to zero.
REQ-006 clk  in  1  clock; all state updates on posedge.
REQ-007 reset  in  1  reset, asynchronous, active-high.
REQ-008 wr_en  in  NUM_WR  per-port write enable.
REQ-009 wr_addr  in  NUM_WR*ADDR_W  write addresses; port k in slice k.
REQ-010 wr_data  in  NUM_WR*DATA_W  write data; port k in slice k.
REQ-011 rd_addr  in  NUM_RD*ADDR_W  read addresses.
REQ-012 rd_data  out  NUM_RD*DATA_W  read data.
REQ-013 rd_busy  out  NUM_RD  scoreboard busy bit of each read address.
REQ-014 rsv_en  in  1  request to reserve the register at rsv_addr (mark pending write).
REQ-015 rsv_addr  in  ADDR_W  register to reserve.
REQ-016 rsv_ok  out  1  reservation accepted this cycle.
REQ-017 busy_vec  out  2**ADDR_W  full scoreboard state.

Function
REQ-018 Reads SHALL be combinational: rd_data[j] = reg[rd_addr[j]], zero latency.
REQ-019 Write on port k SHALL update reg[wr_addr[k]] at posedge clk when wr_en[k]=1.
REQ-020 Multiple ports writing the same address in one cycle: highest-index port SHALL win.
REQ-021 ZERO_REG=1: writes to address 0 SHALL be dropped; reads of address 0 return 0; address 0 never busy.
REQ-022 rsv_ok SHALL equal rsv_en & ~busy[rsv_addr] (combinational); address 0 with ZERO_REG=1 always ok, never set busy.
REQ-023 Accepted reservation SHALL set busy[rsv_addr] at the next posedge.
REQ-024 Any enabled write SHALL clear busy[wr_addr[k]] at the next posedge (write completes pending result).
REQ-025 Same cycle, same address, reservation accepted and write: busy SHALL end set (new reservation wins), data written.
REQ-026 Same cycle, same address, address already busy and write: rsv_ok=0, busy SHALL end clear.
REQ-027 rd_busy[j] SHALL equal busy_vec[rd_addr[j]] as currently registered (no look-ahead).

Reset
REQ-028 reset=1 SHALL immediately clear all registers to 0 and busy_vec to 0, independent of clk.
REQ-029 During reset, rd_data SHALL read 0, rd_busy 0, rsv_ok 0; writes and reservations ignored.
REQ-030 Reset asserted mid-operation SHALL discard all pending reservations; no partial state survives.

Configuration
REQ-031 Macro REGFILE_MP_BYPASS_EN defined: a read of an address written in the same cycle SHALL return the winning wr_data (REQ-020) combinationally, and rd_busy for that address SHALL read 0 unless REQ-025 applies; address 0 with ZERO_REG=1 still reads 0.
REQ-032 Macro undefined: reads SHALL return the pre-write value; new data visible the cycle after the write.

Structure
REQ-033 Shared package regfile_mp_pkg SHALL hold default DATA_W/ADDR_W/NUM_RD/NUM_WR constants and the address/data typedefs.
REQ-034 Scoreboard SHALL be sub-module regfile_mp_sb (busy_vec, rsv_ok, clear/set priority); storage and read muxing stay in regfile_mp.

Verification
REQ-035 Reset then read all 32 addresses on both ports -> all rd_data 0, busy_vec 0.
REQ-036 Port0 writes 0x1111_1111 and port1 writes 0x2222_2222 to address 5 same cycle -> next cycle reg5 = 0x2222_2222.
REQ-037 Write 0xDEAD_BEEF to address 0 (ZERO_REG=1) -> reads 0; rsv_en to address 0 -> rsv_ok=1, busy_vec[0]=0.
REQ-038 Reserve address 7, then rsv_en 7 again -> rsv_ok=0; write 7 -> busy cleared next cycle; write+reserve 7 same cycle while clear -> busy set.
REQ-039 Write 0xCAFE_0001 to address 3 while reading 3: with REGFILE_MP_BYPASS_EN rd_data=0xCAFE_0001 same cycle; without, old value, new value next cycle.
REQ-040 Assert reset mid-cycle with address 9 busy and data 0x55 -> reg9=0, busy_vec=0 immediately, before next clk edge.
